// File: rtl/noc_local_flit_switch.sv
`timescale 1ns/1ps
// Cluster flit switch: LOCAL_PORTS GPU ports plus one uplink.
// Each input has a FIFO. Each output has a round-robin arbiter and a registered stage.
module noc_local_flit_switch #(
  parameter int LOCAL_PORTS = 4,
  parameter int BASE_ID     = 20,
  parameter int FIFO_DEPTH  = 4,
  parameter int FLIT_W      = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [(LOCAL_PORTS+1)*FLIT_W-1:0] in_data,
  input  logic [LOCAL_PORTS:0]              in_valid,
  output logic [LOCAL_PORTS:0]              in_ready,
  output logic [(LOCAL_PORTS+1)*FLIT_W-1:0] out_data,
  output logic [LOCAL_PORTS:0]              out_valid,
  input  logic [LOCAL_PORTS:0]              out_ready,
  output logic [15:0]                       drop_count
);
  localparam int P      = LOCAL_PORTS + 1;
  localparam int PW     = (P > 1) ? $clog2(P) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int UPLINK = LOCAL_PORTS;

  logic [FLIT_W-1:0] mem_q [P][FIFO_DEPTH];
  logic [FLIT_W-1:0] mem_d [P][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q [P];
  logic [AW-1:0]     wr_ptr_d [P];
  logic [AW-1:0]     rd_ptr_q [P];
  logic [AW-1:0]     rd_ptr_d [P];
  logic [CW-1:0]     count_q [P];
  logic [CW-1:0]     count_d [P];
  logic [PW-1:0]     rr_ptr_q [P];
  logic [PW-1:0]     rr_ptr_d [P];
  logic [FLIT_W-1:0] out_data_q [P];
  logic [FLIT_W-1:0] out_data_d [P];
  logic [P-1:0]      out_valid_q, out_valid_d;
  logic [15:0]       drop_count_q, drop_count_d;

  logic [P-1:0]      push, pop, not_empty, drop, can_load, grant_valid;
  logic [FLIT_W-1:0] head [P];
  logic [5:0]        dest [P];
  logic [PW-1:0]     target [P];
  logic [PW-1:0]     grant_src [P];
  logic [PW-1:0]     idx;
  int unsigned       idx_w;

  // FIFO status, head flit and its routing target per input
  always_comb begin
    for (int unsigned i = 0; i < P; i++) begin
      in_ready[i]  = (count_q[i] != CW'(FIFO_DEPTH)) && !ARESET;
      push[i]      = in_valid[i] && in_ready[i];
      not_empty[i] = (count_q[i] != '0);
      head[i]      = mem_q[i][rd_ptr_q[i]];
      dest[i]      = head[i][FLIT_W-1 -: 6];
      if ((32'(dest[i]) >= 32'(BASE_ID)) && (32'(dest[i]) < 32'(BASE_ID + LOCAL_PORTS)))
        target[i] = PW'(32'(dest[i]) - 32'(BASE_ID));
      else
        target[i] = PW'(UPLINK);
      drop[i] = not_empty[i] && (i == 32'(UPLINK)) && (target[i] == PW'(UPLINK));
    end
  end

  // Round-robin search per output starting after the last winner
  always_comb begin
    idx_w = 0;
    idx   = '0;
    for (int unsigned j = 0; j < P; j++) begin
      can_load[j]    = !out_valid_q[j] || out_ready[j];
      grant_valid[j] = 1'b0;
      grant_src[j]   = '0;
      for (int unsigned k = 1; k <= P; k++) begin
        idx_w = 32'(rr_ptr_q[j]) + k;
        if (idx_w >= 32'(P))
          idx_w = idx_w - 32'(P);
        idx = PW'(idx_w);
        if (!grant_valid[j] && not_empty[idx] && !drop[idx] && (target[idx] == PW'(j))) begin
          grant_valid[j] = 1'b1;
          grant_src[j]   = idx;
        end
      end
      grant_valid[j] = grant_valid[j] && can_load[j];
    end
  end

  // Pops, output stage, RR pointers and drop counter next-state
  always_comb begin
    pop = drop;
    for (int unsigned j = 0; j < P; j++) begin
      rr_ptr_d[j]    = rr_ptr_q[j];
      out_data_d[j]  = out_data_q[j];
      out_valid_d[j] = out_valid_q[j];
      if (grant_valid[j]) begin
        pop[grant_src[j]] = 1'b1;
        out_data_d[j]     = head[grant_src[j]];
        out_valid_d[j]    = 1'b1;
        rr_ptr_d[j]       = grant_src[j];
      end else if (out_ready[j]) begin
        out_valid_d[j] = 1'b0;
      end
    end
    drop_count_d = drop_count_q;
    if ((|drop) && (drop_count_q != '1))
      drop_count_d = drop_count_q + 16'd1;
  end

  // FIFO write and pointer/occupancy next-state
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < P; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
      count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (push[i])
        mem_d[i][wr_ptr_q[i]] = in_data[i*FLIT_W +: FLIT_W];
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < P; i++) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        count_q[i]    <= '0;
        rr_ptr_q[i]   <= PW'(P - 1);
        out_data_q[i] <= '0;
      end
      out_valid_q  <= '0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rr_ptr_q     <= rr_ptr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      drop_count_q <= drop_count_d;
    end
  end

  // FIFO storage; contents are don't-care while empty
  always_ff @(posedge ACLK) begin
    mem_q <= mem_d;
  end

  // Pack registered outputs
  always_comb begin
    out_data = '0;
    for (int unsigned j = 0; j < P; j++)
      out_data[j*FLIT_W +: FLIT_W] = out_data_q[j];
  end

  assign out_valid  = out_valid_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_noc_local_flit_switch.sv
`timescale 1ns/1ps
// Scoreboard bench for noc_local_flit_switch.
module tb_noc_local_flit_switch;
  localparam int LP = 4;
  localparam int P  = LP + 1;
  localparam int FW = 16;
  localparam int BASE = 20;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [P*FW-1:0] in_data;
  logic [P-1:0]    in_valid;
  logic [P-1:0]    in_ready;
  logic [P*FW-1:0] out_data;
  logic [P-1:0]    out_valid;
  logic [P-1:0]    out_ready;
  logic [15:0]     drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drop = 0;
  bit mon_en = 1'b0;
  logic [15:0] exp_q [P][$];
  logic [P-1:0] acc;
  int acc_n;
  int budget;
  logic [15:0] got;

  noc_local_flit_switch #(
    .LOCAL_PORTS(LP),
    .BASE_ID(BASE),
    .FIFO_DEPTH(4),
    .FLIT_W(FW)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_count(drop_count)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference routing: returns destination port index for a flit
  function automatic int route(input logic [15:0] f);
    int d;
    d = int'(f[15:10]);
    if (d >= BASE && d < BASE + LP) return d - BASE;
    return LP;
  endfunction

  task automatic model_accept(input int src, input logic [15:0] f);
    int t;
    t = route(f);
    if (src == LP && t == LP) exp_drop++;
    else exp_q[t].push_back(f);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < P; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Compare each transferred output flit against the scoreboard
  always @(negedge ACLK) begin
    if (mon_en) begin
      for (int j = 0; j < P; j++) begin
        if (out_valid[j] === 1'b1 && out_ready[j] === 1'b1) begin
          if (exp_q[j].size() == 0) begin
            check_eq($sformatf("unexpected_out%0d", j), 32'(out_valid[j]), 32'd0);
          end else begin
            got = exp_q[j].pop_front();
            check_eq($sformatf("out%0d_data", j), 32'(out_data[j*FW +: FW]), 32'(got));
          end
        end
      end
    end
  end

  task automatic clk_cycle(output logic [P-1:0] a);
    @(negedge ACLK);
    a = in_valid & in_ready;
    for (int i = 0; i < P; i++)
      if (a[i]) model_accept(i, in_data[i*FW +: FW]);
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    logic [P-1:0] dummy;
    int n = 0;
    while (pending() != 0 && n < limit) begin
      clk_cycle(dummy);
      n++;
    end
    check_eq("drain", 32'(pending()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET    = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;

    // Reset state
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge ACLK); #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data[31:0], 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    ARESET = 1'b0;
    mon_en = 1'b1;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'h1F);

    // Single flit 0x5523 -> out 1
    in_valid[0] = 1'b1;
    in_data[0 +: FW] = 16'h5523;
    clk_cycle(acc);
    check_eq("single_acc", 32'(acc), 32'h01);
    in_valid = '0;
    @(negedge ACLK);
    check_eq("single_not_early", 32'(out_valid), 32'd0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check_eq("single_only_out1", 32'(out_valid), 32'h02);
    check_eq("single_data", 32'(out_data[1*FW +: FW]), 32'h5523);
    check_eq("single_in_ready0", 32'(in_ready[0]), 32'd1);
    @(posedge ACLK); #1;
    wait_drain(10);

    // Contention on out 3, two rounds
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = 1'b1;
        in_data[i*FW +: FW] = 16'h5C00 | 16'(r * 16 + i + 1);
      end
      clk_cycle(acc);
      check_eq("cont_acc", 32'(acc), 32'h07);
      in_valid = '0;
      @(posedge ACLK); #1;
      for (int c = 0; c < 3; c++) begin
        @(negedge ACLK);
        check_eq("cont_consecutive", 32'(out_valid[3]), 32'd1);
        @(posedge ACLK); #1;
      end
      @(negedge ACLK);
      check_eq("cont_done", 32'(out_valid[3]), 32'd0);
      @(posedge ACLK); #1;
      wait_drain(10);
    end

    // Backpressure on out 2
    out_ready[2] = 1'b0;
    acc_n = 0;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data[0 +: FW] = 16'h5800 | 16'(acc_n);
      clk_cycle(acc);
      if (acc[0]) acc_n++;
    end
    check_eq("bp_accepted", 32'(acc_n), 32'd5);
    check_eq("bp_in_ready0", 32'(in_ready[0]), 32'd0);
    check_eq("bp_out_held", 32'(out_data[2*FW +: FW]), 32'h5800);
    in_valid = '0;
    out_ready[2] = 1'b1;
    wait_drain(20);

    // Uplink forwarding from local port 1
    in_valid[1] = 1'b1;
    in_data[1*FW +: FW] = 16'hC0AA;
    clk_cycle(acc);
    in_valid = '0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check_eq("up_valid", 32'(out_valid), 32'h10);
    check_eq("up_data", 32'(out_data[4*FW +: FW]), 32'hC0AA);
    @(posedge ACLK); #1;
    wait_drain(10);

    // Uplink-to-uplink drop
    in_valid[4] = 1'b1;
    in_data[4*FW +: FW] = 16'hC055;
    clk_cycle(acc);
    check_eq("drop_acc", 32'(acc), 32'h10);
    in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      check_eq("drop_no_out", 32'(out_valid), 32'd0);
      @(posedge ACLK); #1;
    end
    check_eq("drop_count1", 32'(drop_count), 32'd1);
    check_eq("drop_in_ready4", 32'(in_ready[4]), 32'd1);

    // Saturation
    in_valid[4] = 1'b1;
    in_data[4*FW +: FW] = 16'hC077;
    budget = 0;
    while (exp_drop < 65540 && budget < 70000) begin
      clk_cycle(acc);
      budget++;
    end
    in_valid = '0;
    repeat (3) clk_cycle(acc);
    check_eq("drop_sat", 32'(drop_count), 32'(exp_drop > 65535 ? 65535 : exp_drop));

    // Reset mid-operation with out 1 stalled
    out_ready = 5'b11101;
    for (int c = 0; c < 3; c++) begin
      in_valid[0] = 1'b1;
      in_data[0 +: FW] = 16'h5401 + 16'(c);
      clk_cycle(acc);
    end
    in_valid = '0;
    for (int i = 0; i < P; i++) exp_q[i].delete();
    ARESET = 1'b1;
    @(negedge ACLK);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge ACLK); #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    ARESET = 1'b0;
    out_ready = '1;
    repeat (6) clk_cycle(acc);
    check_eq("mid_rst_no_stale", 32'(out_valid), 32'd0);
    check_eq("mid_rst_drop", 32'(drop_count), 32'd0);
    in_valid = 5'b10011;
    in_data[0*FW +: FW] = 16'h5411;
    in_data[1*FW +: FW] = 16'h5412;
    in_data[4*FW +: FW] = 16'h5414;
    clk_cycle(acc);
    check_eq("rr_rst_acc", 32'(acc), 32'h13);
    in_valid = '0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check_eq("rr_rst_first", 32'(out_data[1*FW +: FW]), 32'h5411);
    @(posedge ACLK); #1;
    wait_drain(10);

    repeat (2) @(posedge ACLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_local_flit_switch.md
Name: noc_local_flit_switch

Overview:
- Cluster-level switch for the 16-bit GPU network flits, format {dest_gpu[5:0], payload[9:0]}.
- Sits directly downstream of each GPU's network interface: net_data_out/net_valid_out feed in_*, and out_* feed net_data_in/net_valid_in.
- Connects LOCAL_PORTS GPUs plus one uplink port toward the wider NoC.
- Each input has a FIFO; each output has a round-robin arbiter and a registered output stage.

Parameters:
- LOCAL_PORTS, 4: number of GPU-facing ports. Total ports P = LOCAL_PORTS+1; port index LOCAL_PORTS is the uplink.
- BASE_ID, 20: GPU ID attached to local port 0. Local port k serves ID BASE_ID+k.
- FIFO_DEPTH, 4: flits per input FIFO; must be a power of 2, ≥2.
- FLIT_W, 16: flit width; fixed format, dest in [15:10].

Ports:
- ACLK  in  1  clock, all logic on posedge.
- ARESET  in  1  synchronous, active-high reset.
- in_data  in  P*FLIT_W  input flits; port i occupies [i*16+:16].
- in_valid  in  P  per-port flit valid.
- in_ready  out  P  per-port ready.
- out_data  out  P*FLIT_W  output flits, same packing as in_data.
- out_valid  out  P  per-port output valid.
- out_ready  in  P  per-port downstream ready.
- drop_count  out  16  saturating count of dropped uplink flits.

Behaviour:
- Clock and reset: single clock ACLK. Reset is synchronous, active-high ARESET.
- Reset values: out_valid=0, out_data=0, all FIFOs empty, drop_count=0, all RR pointers =P-1 so input 0 has first priority.
- in_ready: in_ready[i] = !fifo_full[i] && !ARESET, combinational from the occupancy counter.
  - A full FIFO does not accept even if it pops in the same cycle.
- Acceptance: a flit is accepted on a posedge with in_valid[i] && in_ready[i]. It is written to FIFO i and visible at the head the next cycle.
- Routing of head flit d = head[15:10]:
  - If BASE_ID ≤ d < BASE_ID+LOCAL_PORTS, the target is port d-BASE_ID. Self-loopback is allowed.
  - Otherwise the target is the uplink.
  - Exception: a head on the uplink input that targets the uplink is dropped. It pops with no output; drop_count increments, saturating at 0xFFFF.
- Output stage: out j can load when !out_valid[j] || out_ready[j].
- Arbitration per output j:
  - Candidates are inputs whose non-empty head targets j.
  - Round-robin search starts at ptr_j+1 mod P. The winner is granted only if out j can load.
  - On grant: out_data[j] <= head, out_valid[j] <= 1, pop FIFO, ptr_j <= winner.
  - No grant: ptr_j holds. out_valid[j] clears if out_ready[j] was asserted and nothing loads.
- Heads never conflict across outputs, because each head has exactly one target.
- Latency: flit accepted at edge N can be on out at edge N+1 at earliest, i.e. valid in the cycle after acceptance. Throughput is 1 flit/cycle/output.
- Ordering: flits from the same input to the same output keep order. Head-of-line blocking is intended behaviour.
- FIFO pointers: log2(FIFO_DEPTH) bits, wrap naturally. Occupancy count has one extra bit.
- Reset mid-operation: all in-flight flits, including registered outputs, are discarded. Outputs take reset values at the first reset edge.
- Data is never modified in transit.

Test Plan:
- Single flit: after reset, port 0 sends 0x5523 (dest 21, payload 0x123). Required:
  - out_valid[1]=1, out_data[1]=0x5523 the cycle after acceptance.
  - Only out 1 is valid.
  - in_ready[0] stays 1.
- Contention: ports 0,1,2 each send one flit to dest 23 (port 3) in the same cycle, out_ready=all 1. Required:
  - out 3 delivers input 0, then 1, then 2 on consecutive cycles.
  - Next round starting with input 2 pending yields 2 first only after 0 and 1 pass.
- Backpressure: out_ready[2]=0, port 0 streams to dest 22 each cycle. Required:
  - Exactly 5 flits accepted (1 in output reg, 4 in FIFO), then in_ready[0]=0.
  - Raising out_ready[2] drains all 5 in order with no loss or duplicate.
- Uplink:
  - Port 1 sends 0xC0AA (dest 48). Required: appears on out[4] one cycle later.
  - Uplink input sends dest 48. Required: no output, drop_count=1, in_ready[4] stays 1.
  - 0x10000 drops. Required: drop_count holds 0xFFFF.
- Reset mid-operation: fill FIFO 0 with 3 flits, assert ARESET one cycle. Required:
  - out_valid=0 and in_ready=0 during reset.
  - After reset, no stale flit ever appears.
  - drop_count=0, and the next grant to out 1 goes to input 0 first.
